// File: rtl/bp_angle_scheduler_if.sv
// Handshake bundle between the host angle source, bp_angle_scheduler and the PE lane array.
// The master modport is the scheduler side; slave is the source/lane side.
`ifndef kAngleLength
`define kAngleLength 16
`endif

interface bp_angle_scheduler_if #(
  parameter int NUM_PE      = 4,
  parameter int ANGLE_WIDTH = `kAngleLength
);
  logic [ANGLE_WIDTH-1:0] hs_angle;
  logic                   hs_has_next_angle;
  logic                   hs_next_angle_ack;
  logic                   hs_next_angle;
  logic [ANGLE_WIDTH-1:0] pe_angle;
  logic [NUM_PE-1:0]      pe_valid;
  logic [NUM_PE-1:0]      pe_ready;
  logic [NUM_PE-1:0]      pe_done;

  modport master (
    input  hs_angle, hs_has_next_angle, hs_next_angle_ack, pe_ready, pe_done,
    output hs_next_angle, pe_angle, pe_valid
  );

  modport slave (
    output hs_angle, hs_has_next_angle, hs_next_angle_ack, pe_ready, pe_done,
    input  hs_next_angle, pe_angle, pe_valid
  );
endinterface

// File: rtl/bp_angle_scheduler.sv
// Dispatches host angles one at a time to idle backprojection lanes and signals end of run.
// Define BP_ANGLE_SCHED_RR_EN for round-robin lane choice; default is lowest-index idle lane.
`ifndef kAngleLength
`define kAngleLength 16
`endif

module bp_angle_scheduler #(
  parameter int NUM_PE      = 4,
  parameter int ANGLE_WIDTH = `kAngleLength,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  bp_angle_scheduler_if.master   bus,
  output logic [NUM_PE-1:0]      pe_busy,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] angle_count
);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_OFFER, S_ADVANCE, S_DRAIN, S_DONE
  } state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       grant, grant_next;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  logic                   accept;
  logic [ANGLE_WIDTH-1:0] pe_angle_q, pe_angle_next;
  logic [NUM_PE-1:0]      pe_valid_q, pe_valid_next;
  logic [NUM_PE-1:0]      pe_busy_next;
  logic [COUNT_WIDTH-1:0] count_next;
`ifdef BP_ANGLE_SCHED_RR_EN
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_next;
`endif

  assign bus.pe_angle      = pe_angle_q;
  assign bus.pe_valid      = pe_valid_q;
  assign bus.hs_next_angle = (state == S_ADVANCE);
  assign accept            = (state == S_OFFER) && bus.pe_ready[grant];

  // Lane picker: only lanes whose registered busy bit is clear are candidates.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_PE; k++) begin
`ifdef BP_ANGLE_SCHED_RR_EN
      if (!sel_found && !pe_busy[(int'(rr_ptr) + k) % NUM_PE]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_PE);
      end
`else
      if (!sel_found && !pe_busy[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch can be inferred.
    state_next    = state;
    grant_next    = grant;
    pe_angle_next = pe_angle_q;
    pe_valid_next = '0;
    count_next    = angle_count;
    pe_busy_next  = pe_busy & ~bus.pe_done;
`ifdef BP_ANGLE_SCHED_RR_EN
    rr_ptr_next   = rr_ptr;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          count_next = '0;
          state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_found) begin
          grant_next    = sel_idx;
          pe_angle_next = bus.hs_angle;
          pe_valid_next = NUM_PE'(1) << sel_idx;
          state_next    = S_OFFER;
        end
      end
      S_OFFER: begin
        if (accept) begin
          pe_busy_next[grant] = 1'b1;
          count_next          = angle_count + COUNT_WIDTH'(1);
`ifdef BP_ANGLE_SCHED_RR_EN
          rr_ptr_next = (int'(grant) == NUM_PE - 1) ? '0 : grant + IDX_W'(1);
`endif
          state_next  = bus.hs_has_next_angle ? S_ADVANCE : S_DRAIN;
        end else begin
          pe_valid_next = pe_valid_q;
        end
      end
      S_ADVANCE: state_next = bus.hs_next_angle_ack ? S_SELECT : S_DRAIN;
      // A completion arriving this cycle already counts as drained.
      S_DRAIN:   if (pe_busy_next == '0) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= '0;
      pe_angle_q  <= '0;
      pe_valid_q  <= '0;
      pe_busy     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      angle_count <= '0;
`ifdef BP_ANGLE_SCHED_RR_EN
      rr_ptr      <= '0;
`endif
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      pe_angle_q  <= pe_angle_next;
      pe_valid_q  <= pe_valid_next;
      pe_busy     <= pe_busy_next;
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
      angle_count <= count_next;
`ifdef BP_ANGLE_SCHED_RR_EN
      rr_ptr      <= rr_ptr_next;
`endif
    end
  end
endmodule

// File: tb/tb_bp_angle_scheduler.sv
// Directed bench for bp_angle_scheduler: host source model, lane model with timed completions.
// Lane expectations in test_fixed_priority follow BP_ANGLE_SCHED_RR_EN when it is defined.
module tb_bp_angle_scheduler;
  localparam int NPE = 4;
  localparam int AW  = 16;
  localparam int CW  = 8;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [NPE-1:0] pe_busy;
  logic           busy;
  logic           done;
  logic [CW-1:0]  angle_count;

  bp_angle_scheduler_if #(.NUM_PE(NPE), .ANGLE_WIDTH(AW)) bus ();

  bp_angle_scheduler #(.NUM_PE(NPE), .ANGLE_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .pe_busy    (pe_busy),
    .busy       (busy),
    .done       (done),
    .angle_count(angle_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Host source: angle = base + idx*step, has_next while idx < n-1.
  int   src_base = 0;
  int   src_step = 45;
  int   src_n    = 1;
  int   src_idx  = 0;
  logic ack_en   = 1'b1;

  assign bus.hs_angle          = AW'(src_base + src_idx * src_step);
  assign bus.hs_has_next_angle = (src_idx < src_n - 1);
  assign bus.hs_next_angle_ack = bus.hs_next_angle & ack_en;

  always @(negedge clk) begin
    if (reset) src_idx = 0;
    else if (bus.hs_next_angle && ack_en) src_idx++;
  end

  // Lanes: completion pulse lane_delay cycles after accept (0 = never, manual only).
  logic [NPE-1:0] ready_mask  = '1;
  logic [NPE-1:0] manual_done = '0;
  logic [NPE-1:0] auto_done   = '0;
  int             lane_delay  = 0;
  int             timer [NPE];

  assign bus.pe_ready = ready_mask;
  assign bus.pe_done  = auto_done | manual_done;

  always @(negedge clk) begin
    for (int i = 0; i < NPE; i++) begin
      if (reset) begin
        timer[i]     = 0;
        auto_done[i] = 1'b0;
      end else begin
        auto_done[i] = 1'b0;
        if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) auto_done[i] = 1'b1;
        end
        if (bus.pe_valid[i] && ready_mask[i] && lane_delay > 0) timer[i] = lane_delay;
      end
    end
  end

  // Monitor: dispatch log, source-advance pulses, done pulses.
  int lane_q [$];
  int angle_q[$];
  int hs_pulses   = 0;
  int done_pulses = 0;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NPE; i++)
        if (bus.pe_valid[i] && ready_mask[i]) begin
          lane_q.push_back(i);
          angle_q.push_back(int'(bus.pe_angle));
        end
      if (bus.hs_next_angle) hs_pulses++;
      if (done) done_pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    start       = 1'b0;
    manual_done = '0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_pulses;
    int n  = 0;
    while (done_pulses == d0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (done_pulses == d0) begin
      fails++;
      $display("FAIL %s_done_timeout: no done pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests_run++;
    if (bus.pe_valid !== '0 || bus.pe_angle !== '0 || pe_busy !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || angle_count !== '0 || bus.hs_next_angle !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: valid=%b angle=%0d pe_busy=%b busy=%b done=%b cnt=%0d next=%b, all required 0",
               bus.pe_valid, bus.pe_angle, pe_busy, busy, done, angle_count, bus.hs_next_angle);
    end
    reset = 1'b0;
  endtask

  task automatic test_spread();
    int base, h0, d0;
    int exp_lane[4] = '{0, 1, 2, 3};
    int exp_ang [4] = '{0, 45, 90, 135};
    apply_reset();
    src_base = 0; src_step = 45; src_n = 4;
    ready_mask = '1; lane_delay = 20;
    base = lane_q.size(); h0 = hs_pulses; d0 = done_pulses;
    pulse_start();
    wait_done(300, "spread");
    tests_run++;
    if (pe_busy !== '0) begin
      fails++;
      $display("FAIL spread_drained: pe_busy=%b after done, required 0000", pe_busy);
    end
    repeat (30) tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (lane_q.size() <= base + k || lane_q[base+k] !== exp_lane[k] || angle_q[base+k] !== exp_ang[k]) begin
        fails++;
        $display("FAIL spread_dispatch%0d: got lane/angle %0d/%0d, required %0d/%0d", k,
                 (lane_q.size() > base + k) ? lane_q[base+k] : -1,
                 (angle_q.size() > base + k) ? angle_q[base+k] : -1, exp_lane[k], exp_ang[k]);
      end
    end
    tests_run++;
    if (hs_pulses - h0 !== 3) begin
      fails++;
      $display("FAIL spread_next_pulses: got %0d, required 3", hs_pulses - h0);
    end
    tests_run++;
    if (done_pulses - d0 !== 1 || angle_count !== CW'(4) || busy !== 1'b0) begin
      fails++;
      $display("FAIL spread_end: done_pulses=%0d cnt=%0d busy=%b, required 1/4/0",
               done_pulses - d0, angle_count, busy);
    end
  endtask

  task automatic test_fixed_priority();
    int base;
`ifdef BP_ANGLE_SCHED_RR_EN
    int exp_lane[4] = '{0, 1, 2, 3};
`else
    int exp_lane[4] = '{0, 0, 0, 0};
`endif
    int exp_ang [4] = '{0, 45, 90, 135};
    apply_reset();
    src_base = 0; src_step = 45; src_n = 4;
    ready_mask = '1; lane_delay = 1;
    base = lane_q.size();
    pulse_start();
    wait_done(200, "prio");
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (lane_q.size() <= base + k || lane_q[base+k] !== exp_lane[k] || angle_q[base+k] !== exp_ang[k]) begin
        fails++;
        $display("FAIL prio_dispatch%0d: got lane/angle %0d/%0d, required %0d/%0d", k,
                 (lane_q.size() > base + k) ? lane_q[base+k] : -1,
                 (angle_q.size() > base + k) ? angle_q[base+k] : -1, exp_lane[k], exp_ang[k]);
      end
    end
    tests_run++;
    if (angle_count !== CW'(4)) begin
      fails++;
      $display("FAIL prio_count: got %0d, required 4", angle_count);
    end
  endtask

  task automatic test_all_busy_stall();
    int   base, n;
    logic stall_ok;
    apply_reset();
    src_base = 0; src_step = 45; src_n = 5;
    ready_mask = '1; lane_delay = 0;
    base = lane_q.size();
    pulse_start();
    n = 0;
    while (lane_q.size() < base + 4 && n < 100) begin tick(); n++; end
    stall_ok = 1'b1;
    repeat (10) begin
      tick();
      if (bus.pe_valid !== '0) stall_ok = 1'b0;
    end
    tests_run++;
    if (!stall_ok || pe_busy !== 4'b1111 || lane_q.size() !== base + 4) begin
      fails++;
      $display("FAIL stall_select: valid_quiet=%b pe_busy=%b dispatched=%0d, required 1/1111/4",
               stall_ok, pe_busy, lane_q.size() - base);
    end
    manual_done = 4'b0100;
    tick();
    manual_done = '0;
    n = 0;
    while (lane_q.size() < base + 5 && n < 20) begin tick(); n++; end
    tests_run++;
    if (lane_q.size() <= base + 4 || lane_q[base+4] !== 2 || angle_q[base+4] !== 180) begin
      fails++;
      $display("FAIL stall_redispatch: got lane/angle %0d/%0d, required 2/180",
               (lane_q.size() > base + 4) ? lane_q[base+4] : -1,
               (angle_q.size() > base + 4) ? angle_q[base+4] : -1);
    end
    tick();
    manual_done = 4'b1111;
    tick();
    manual_done = '0;
    wait_done(20, "stall");
    tests_run++;
    if (angle_count !== CW'(5)) begin
      fails++;
      $display("FAIL stall_count: got %0d, required 5", angle_count);
    end
  endtask

  task automatic test_ready_withheld();
    int   base, n;
    logic stable_ok, none_ok;
    apply_reset();
    src_base = 90; src_step = 0; src_n = 1;
    ready_mask = 4'b1110; lane_delay = 3;
    base = lane_q.size();
    pulse_start();
    n = 0;
    while (bus.pe_valid === '0 && n < 20) begin tick(); n++; end
    stable_ok = 1'b1;
    none_ok   = 1'b1;
    repeat (10) begin
      if (bus.pe_valid !== 4'b0001 || bus.pe_angle !== AW'(90)) stable_ok = 1'b0;
      if (pe_busy !== '0 || lane_q.size() !== base) none_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (!stable_ok) begin
      fails++;
      $display("FAIL hold_offer: valid=%b angle=%0d, required 0001/90 for the whole stall",
               bus.pe_valid, bus.pe_angle);
    end
    tests_run++;
    if (!none_ok) begin
      fails++;
      $display("FAIL hold_no_other: pe_busy=%b dispatched=%0d, required 0000/0",
               pe_busy, lane_q.size() - base);
    end
    ready_mask = '1;
    wait_done(50, "hold");
    tests_run++;
    if (lane_q.size() !== base + 1 || lane_q[base] !== 0 || angle_q[base] !== 90 || angle_count !== CW'(1)) begin
      fails++;
      $display("FAIL hold_dispatch: dispatched=%0d cnt=%0d, required one dispatch lane0/90 cnt 1",
               lane_q.size() - base, angle_count);
    end
  endtask

  task automatic test_exhausted_source();
    int base, h0, d0;
    apply_reset();
    src_base = 135; src_step = 45; src_n = 1;
    ready_mask = '1; lane_delay = 5;
    base = lane_q.size(); h0 = hs_pulses; d0 = done_pulses;
    pulse_start();
    wait_done(50, "single");
    repeat (10) tick();
    tests_run++;
    if (lane_q.size() !== base + 1 || lane_q[base] !== 0 || angle_q[base] !== 135) begin
      fails++;
      $display("FAIL single_dispatch: dispatched=%0d, required exactly one lane0/135", lane_q.size() - base);
    end
    tests_run++;
    if (hs_pulses - h0 !== 0 || done_pulses - d0 !== 1 || angle_count !== CW'(1)) begin
      fails++;
      $display("FAIL single_end: next_pulses=%0d done_pulses=%0d cnt=%0d, required 0/1/1",
               hs_pulses - h0, done_pulses - d0, angle_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int base, n;
    apply_reset();
    src_base = 0; src_step = 45; src_n = 4;
    ready_mask = 4'b0011; lane_delay = 0;
    pulse_start();
    n = 0;
    while (bus.pe_valid !== 4'b0100 && n < 40) begin tick(); n++; end
    pulse_start();
    repeat (3) tick();
    tests_run++;
    if (bus.pe_valid !== 4'b0100 || bus.pe_angle !== AW'(90) || angle_count !== CW'(2) || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_start_ignored: valid=%b angle=%0d cnt=%0d busy=%b, required 0100/90/2/1",
               bus.pe_valid, bus.pe_angle, angle_count, busy);
    end
    reset = 1'b1;
    src_n = 2;
    tick();
    tests_run++;
    if (bus.pe_valid !== '0 || bus.pe_angle !== '0 || pe_busy !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || angle_count !== '0 || bus.hs_next_angle !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: valid=%b angle=%0d pe_busy=%b busy=%b done=%b cnt=%0d, required all 0",
               bus.pe_valid, bus.pe_angle, pe_busy, busy, done, angle_count);
    end
    reset = 1'b0;
    ready_mask = '1; lane_delay = 4;
    base = lane_q.size();
    pulse_start();
    wait_done(100, "rerun");
    tests_run++;
    if (lane_q.size() !== base + 2 || lane_q[base] !== 0 || angle_q[base] !== 0 ||
        lane_q[base+1] !== 1 || angle_q[base+1] !== 45 || angle_count !== CW'(2)) begin
      fails++;
      $display("FAIL rerun_dispatch: dispatched=%0d cnt=%0d, required lane0/0 lane1/45 cnt 2",
               lane_q.size() - base, angle_count);
    end
  endtask

  initial begin
    test_reset();
    test_spread();
    test_fixed_priority();
    test_all_busy_stall();
    test_ready_withheld();
    test_exhausted_source();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
